// File: rtl/accum_arbiter.sv
// Purpose : round-robin arbiter sharing one 4-lane accumulator among NREQ requesters, sequencing its en/done four-phase handshake.
// Latency : grant->acc_en 1 cycle; nominal req-to-ack 5 cycles with a 1-edge accumulator; next acc_en earliest 2 cycles after ack.
// Backpr. : req held until ack; new requests wait while busy; a stuck done edge is abandoned after TIMEOUT cycles and err is raised.
//
// Ports:
//   clk, reset_l          clock, asynchronous active-low reset
//   req / req_add         per-requester request and 4-lane add vector (r,l at [(r*4+l)*ADD_WIDTH +: ADD_WIDTH])
//   ack / grant_id / busy one-cycle completion pulse, current/last granted index, FSM not idle
//   acc_en / acc_add      accumulator enable and latched lanes (lane l at [l*ADD_WIDTH +: ADD_WIDTH])
//   acc_done              accumulator done
//   err / txn_count       sticky timeout flag, completed-transaction counter (wraps)
module accum_arbiter #(
    parameter int NREQ      = 4,
    parameter int ADD_WIDTH = 64,
    parameter int TIMEOUT   = 16
) (
    input  logic                          clk,
    input  logic                          reset_l,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ*4*ADD_WIDTH-1:0]   req_add,
    output logic [NREQ-1:0]               ack,
    output logic [$clog2(NREQ)-1:0]       grant_id,
    output logic                          busy,
    output logic                          acc_en,
    output logic [4*ADD_WIDTH-1:0]        acc_add,
    input  logic                          acc_done,
    output logic                          err,
    output logic [15:0]                   txn_count
);

    localparam int IDW     = $clog2(NREQ);
    localparam int CW      = $clog2(TIMEOUT);
    localparam int LANES_W = 4 * ADD_WIDTH;
    localparam logic [CW-1:0]  CNT_MAX  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       last_q, last_d;
    logic [IDW-1:0]       grant_id_q, grant_id_d;
    logic [NREQ-1:0]      mask_q, mask_d;
    logic [NREQ-1:0]      ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic                 acc_en_q, acc_en_d;
    logic [LANES_W-1:0]   acc_add_q, acc_add_d;
    logic                 err_q, err_d;
    logic [15:0]          txn_count_q, txn_count_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic [NREQ-1:0]      eligible;
    logic [NREQ-1:0]      grant_oh;
    logic [IDW-1:0]       pick_id;
    logic [IDW-1:0]       cand;
    logic                 pick_found;

    // The requester just acked is masked for one IDLE cycle so it can
    // drop req a cycle late without being granted a second time.
    assign eligible = req & ~mask_q;
    assign grant_oh = NREQ'(1) << grant_id_q;

    // Round-robin search starting one past the last grant.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = last_q;
        cand       = last_q;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDW'((int'(last_q) + i) % NREQ);
            if (!pick_found && eligible[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_id_d  = grant_id_q;
        mask_d      = mask_q;
        ack_d       = '0;
        acc_en_d    = acc_en_q;
        acc_add_d   = acc_add_q;
        err_d       = err_q;
        txn_count_d = txn_count_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                mask_d = '0;
                if (pick_found) begin
                    state_d    = ISSUE;
                    grant_id_d = pick_id;
                    last_d     = pick_id;
                    acc_add_d  = req_add[int'(pick_id)*LANES_W +: LANES_W];
                    acc_en_d   = 1'b1;
                    cnt_d      = '0;
                end
            end
            ISSUE: begin
                // A done already high here (stale) also lands in RELEASE,
                // which then waits for it to fall.
                if (acc_done) begin
                    acc_en_d = 1'b0;
                    state_d  = RELEASE;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_MAX) begin
                    err_d    = 1'b1;
                    acc_en_d = 1'b0;
                    state_d  = RELEASE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RELEASE: begin
                if (!acc_done || cnt_q == CNT_MAX) begin
                    if (acc_done) begin
                        err_d = 1'b1;
                    end
                    state_d     = ACK;
                    ack_d       = grant_oh;
                    txn_count_d = txn_count_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ACK: begin
                mask_d  = grant_oh;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= IDLE;
            last_q      <= LAST_RST;
            grant_id_q  <= '0;
            mask_q      <= '0;
            ack_q       <= '0;
            busy_q      <= 1'b0;
            acc_en_q    <= 1'b0;
            acc_add_q   <= '0;
            err_q       <= 1'b0;
            txn_count_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_id_q  <= grant_id_d;
            mask_q      <= mask_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            acc_en_q    <= acc_en_d;
            acc_add_q   <= acc_add_d;
            err_q       <= err_d;
            txn_count_q <= txn_count_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ack       = ack_q;
    assign grant_id  = grant_id_q;
    assign busy      = busy_q;
    assign acc_en    = acc_en_q;
    assign acc_add   = acc_add_q;
    assign err       = err_q;
    assign txn_count = txn_count_q;

endmodule

// File: tb/tb_accum_arbiter.sv
// Purpose : bench for accum_arbiter with a one-edge model accumulator and an expected-grant queue.
// Latency : outputs sampled 1 time unit after each rising edge; cycle 0 is the cycle in which req is raised.
// Backpr. : every wait is bounded by a cycle budget; a global watchdog ends the run if anything stalls.
module tb_accum_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 64;

    logic                    clk = 1'b0;
    logic                    reset_l = 1'b0;
    logic [NREQ-1:0]         req = '0;
    logic [NREQ*4*AW-1:0]    req_add = '0;
    logic [NREQ-1:0]         ack;
    logic [1:0]              grant_id;
    logic                    busy;
    logic                    acc_en;
    logic [4*AW-1:0]         acc_add;
    logic                    acc_done;
    logic                    err;
    logic [15:0]             txn_count;

    logic                    tie0  = 1'b0;
    logic                    stale = 1'b0;
    logic                    done_q;
    logic [AW-1:0]           lane [4];

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    accum_arbiter #(.NREQ(NREQ), .ADD_WIDTH(AW), .TIMEOUT(16)) dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .req       (req),
        .req_add   (req_add),
        .ack       (ack),
        .grant_id  (grant_id),
        .busy      (busy),
        .acc_en    (acc_en),
        .acc_add   (acc_add),
        .acc_done  (acc_done),
        .err       (err),
        .txn_count (txn_count)
    );

    // Model accumulator: adds once per en rising phase, done follows one edge later.
    assign acc_done = tie0 ? 1'b0 : (stale ? 1'b1 : done_q);

    always @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            done_q <= 1'b0;
            for (int l = 0; l < 4; l++) lane[l] <= '0;
        end else if (acc_en && !acc_done) begin
            for (int l = 0; l < 4; l++) lane[l] <= lane[l] + acc_add[l*AW +: AW];
            done_q <= 1'b1;
        end else if (!acc_en && done_q) begin
            done_q <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_l = 1'b0;
        req     = '0;
        tie0    = 1'b0;
        stale   = 1'b0;
        exp_q.delete();
        tick();
        reset_l = 1'b1;
    endtask

    task automatic set_lane(input int r, input int l, input logic [AW-1:0] v);
        req_add[(r*4+l)*AW +: AW] = v;
    endtask

    task automatic sb_pop(output int id, output bit empty);
        if (exp_q.size() == 0) begin
            empty = 1'b1;
            id    = 0;
        end else begin
            empty = 1'b0;
            id    = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        reset_l = 1'b0;
        tick();
        tick();
        checks++;
        if (acc_en !== 1'b0 || busy !== 1'b0 || ack !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl acc_en=%b busy=%b ack=%b required 0 0 0000", acc_en, busy, ack);
        end
        checks++;
        if (acc_add !== '0 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_data acc_add=%h grant_id=%0d required 0 0", acc_add, grant_id);
        end
        checks++;
        if (err !== 1'b0 || txn_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_status err=%b txn_count=%0d required 0 0", err, txn_count);
        end
        reset_l = 1'b1;
    endtask

    task automatic test_single();
        int ack_cyc = -1;
        int en_bad  = 0;
        int id;
        bit empty;
        do_reset();
        for (int l = 0; l < 4; l++) set_lane(0, l, AW'(l + 1));
        exp_q.push_back(0);
        req = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            tick();
            // Lanes written after grant must not reach the accumulator.
            if (k == 1) for (int l = 0; l < 4; l++) set_lane(0, l, AW'(100 + l));
            if (acc_en !== ((k == 1) || (k == 2))) en_bad++;
            if (ack !== '0) begin
                if (ack_cyc < 0) ack_cyc = k;
                sb_pop(id, empty);
                checks++;
                if (empty || ack !== (4'b0001 << id)) begin
                    failures++;
                    $display("FAIL single_ack ack=%b at cycle %0d required %b", ack, k, 4'b0001 << id);
                end
                req = '0;
            end
        end
        checks++;
        if (en_bad != 0) begin
            failures++;
            $display("FAIL single_en_window bad_cycles=%0d required 0 (en only in cycles 1-2)", en_bad);
        end
        checks++;
        if (ack_cyc != 5) begin
            failures++;
            $display("FAIL single_ack_cycle got=%0d required 5", ack_cyc);
        end
        checks++;
        if (lane[0] !== 64'd1 || lane[1] !== 64'd2 || lane[2] !== 64'd3 || lane[3] !== 64'd4) begin
            failures++;
            $display("FAIL single_lanes got=%0d,%0d,%0d,%0d required 1,2,3,4", lane[0], lane[1], lane[2], lane[3]);
        end
        checks++;
        if (txn_count !== 16'd1) begin
            failures++;
            $display("FAIL single_txn got=%0d required 1", txn_count);
        end
    endtask

    task automatic test_round_robin();
        int n = 0;
        int id;
        bit empty;
        do_reset();
        for (int r = 0; r < 4; r++)
            for (int l = 0; l < 4; l++) set_lane(r, l, AW'(r + 1));
        for (int t = 0; t < 8; t++) exp_q.push_back(t % 4);
        req = 4'b1111;
        for (int k = 1; k <= 150 && n < 8; k++) begin
            tick();
            if (ack !== '0) begin
                n++;
                sb_pop(id, empty);
                checks++;
                if (empty || ack !== (4'b0001 << id) || grant_id !== 2'(id)) begin
                    failures++;
                    $display("FAIL rr_grant txn=%0d ack=%b grant_id=%0d required ack=%b id=%0d", n, ack, grant_id, 4'b0001 << id, id);
                end
                if (n == 8) req = '0;
            end
        end
        checks++;
        if (n != 8) begin
            failures++;
            $display("FAIL rr_timeout acks=%0d required 8", n);
        end
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (lane[0] !== 64'd20 || lane[1] !== 64'd20 || lane[2] !== 64'd20 || lane[3] !== 64'd20) begin
            failures++;
            $display("FAIL rr_lanes got=%0d,%0d,%0d,%0d required 20 each", lane[0], lane[1], lane[2], lane[3]);
        end
        checks++;
        if (txn_count !== 16'd8) begin
            failures++;
            $display("FAIL rr_txn got=%0d required 8", txn_count);
        end
    endtask

    task automatic test_mask();
        int id;
        int got;
        int stray;
        bit empty;
        do_reset();
        // Requester 2 alone holds req one cycle past its ack: no second grant.
        exp_q.push_back(2);
        req = 4'b0100;
        got = 0;
        for (int k = 1; k <= 20 && got == 0; k++) begin
            tick();
            if (ack !== '0) begin
                got = 1;
                sb_pop(id, empty);
                checks++;
                if (empty || ack !== (4'b0001 << id)) begin
                    failures++;
                    $display("FAIL mask_first_ack ack=%b required %b", ack, 4'b0001 << id);
                end
            end
        end
        tick();
        tick();
        req = '0;
        stray = 0;
        for (int k = 0; k < 10; k++) begin
            if (busy !== 1'b0 || ack !== '0) stray++;
            tick();
        end
        checks++;
        if (got == 0 || stray != 0) begin
            failures++;
            $display("FAIL mask_regrant acked=%0d busy_or_ack_cycles=%0d required 1 0", got, stray);
        end
        // Requester 2 held past ack while requester 1 rises: 1 wins next.
        exp_q.push_back(2);
        exp_q.push_back(1);
        req = 4'b0100;
        got = 0;
        for (int k = 1; k <= 40 && got < 2; k++) begin
            tick();
            if (ack !== '0) begin
                got++;
                sb_pop(id, empty);
                checks++;
                if (empty || ack !== (4'b0001 << id) || grant_id !== 2'(id)) begin
                    failures++;
                    $display("FAIL mask_order ack=%b grant_id=%0d required ack=%b id=%0d", ack, grant_id, 4'b0001 << id, id);
                end
                if (got == 1) begin
                    tick();
                    req = 4'b0110;
                    tick();
                    req = 4'b0010;
                end else begin
                    req = '0;
                end
            end
        end
        checks++;
        if (got != 2) begin
            failures++;
            $display("FAIL mask_timeout acks=%0d required 2", got);
        end
    endtask

    task automatic test_timeout();
        int en_cnt  = 0;
        int ack_cyc = -1;
        int id;
        bit empty;
        do_reset();
        tie0 = 1'b1;
        exp_q.push_back(0);
        req = 4'b0001;
        for (int k = 1; k <= 40 && ack_cyc < 0; k++) begin
            tick();
            if (acc_en === 1'b1) en_cnt++;
            if (ack !== '0) begin
                ack_cyc = k;
                sb_pop(id, empty);
                checks++;
                if (empty || ack !== (4'b0001 << id)) begin
                    failures++;
                    $display("FAIL to_ack ack=%b required %b", ack, 4'b0001 << id);
                end
                req = '0;
            end
        end
        checks++;
        if (en_cnt != 16) begin
            failures++;
            $display("FAIL to_en_cycles got=%0d required 16", en_cnt);
        end
        checks++;
        if (ack_cyc != 18) begin
            failures++;
            $display("FAIL to_ack_cycle got=%0d required 18", ack_cyc);
        end
        checks++;
        if (err !== 1'b1 || txn_count !== 16'd1) begin
            failures++;
            $display("FAIL to_status err=%b txn=%0d required 1 1", err, txn_count);
        end
        // err must not block the next transaction.
        tie0 = 1'b0;
        exp_q.push_back(1);
        req = 4'b0010;
        ack_cyc = -1;
        for (int k = 1; k <= 20 && ack_cyc < 0; k++) begin
            tick();
            if (ack !== '0) begin
                ack_cyc = k;
                sb_pop(id, empty);
                checks++;
                if (empty || ack !== (4'b0001 << id)) begin
                    failures++;
                    $display("FAIL to_after_ack ack=%b required %b", ack, 4'b0001 << id);
                end
                req = '0;
            end
        end
        checks++;
        if (ack_cyc < 0 || err !== 1'b1 || txn_count !== 16'd2) begin
            failures++;
            $display("FAIL to_after_status ack_cycle=%0d err=%b txn=%0d required acked 1 2", ack_cyc, err, txn_count);
        end
    endtask

    task automatic test_reset_mid();
        int ack_cyc = -1;
        int id;
        bit empty;
        req = 4'b0001;
        tick();
        tick();
        tick();
        checks++;
        if (busy !== 1'b1 || err !== 1'b1) begin
            failures++;
            $display("FAIL rmid_pre busy=%b err=%b required 1 1", busy, err);
        end
        reset_l = 1'b0;
        #1;
        checks++;
        if (acc_en !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || txn_count !== 16'd0 || ack !== '0) begin
            failures++;
            $display("FAIL rmid_async acc_en=%b busy=%b err=%b txn=%0d ack=%b required 0 0 0 0 0000", acc_en, busy, err, txn_count, ack);
        end
        req = 4'b1000;
        tick();
        reset_l = 1'b1;
        exp_q.push_back(3);
        for (int k = 1; k <= 20 && ack_cyc < 0; k++) begin
            tick();
            if (ack !== '0) begin
                ack_cyc = k;
                sb_pop(id, empty);
                checks++;
                if (empty || ack !== (4'b0001 << id) || grant_id !== 2'(id)) begin
                    failures++;
                    $display("FAIL rmid_grant ack=%b grant_id=%0d required ack=%b id=%0d", ack, grant_id, 4'b0001 << id, id);
                end
                req = '0;
            end
        end
        checks++;
        if (ack_cyc < 0) begin
            failures++;
            $display("FAIL rmid_timeout ack_cycle=%0d required an ack", ack_cyc);
        end
    endtask

    task automatic test_stale();
        int ack_cyc = -1;
        int en_bad  = 0;
        int id;
        bit empty;
        reset_l = 1'b0;
        req     = '0;
        stale   = 1'b1;
        exp_q.delete();
        tick();
        reset_l = 1'b1;
        for (int l = 0; l < 4; l++) set_lane(0, l, AW'(7));
        exp_q.push_back(0);
        req = 4'b0001;
        for (int k = 1; k <= 20 && ack_cyc < 0; k++) begin
            tick();
            if (acc_en !== (k == 1)) en_bad++;
            if (ack !== '0) begin
                ack_cyc = k;
                sb_pop(id, empty);
                checks++;
                if (empty || ack !== (4'b0001 << id)) begin
                    failures++;
                    $display("FAIL stale_ack ack=%b required %b", ack, 4'b0001 << id);
                end
                req = '0;
            end
            if (k == 8) stale = 1'b0;
        end
        checks++;
        if (ack_cyc != 9 || en_bad != 0) begin
            failures++;
            $display("FAIL stale_timing ack_cycle=%0d en_bad=%0d required 9 0", ack_cyc, en_bad);
        end
        checks++;
        if (lane[0] !== '0 || lane[3] !== '0 || err !== 1'b0) begin
            failures++;
            $display("FAIL stale_no_update lane0=%0d lane3=%0d err=%b required 0 0 0", lane[0], lane[3], err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d required run to complete", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_mask();
        test_timeout();
        test_reset_mid();
        test_stale();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
